// File: rtl/timing_io_gen.sv
// rtl/timing_io_gen.sv - 4004 two-phase timing generator and I/O pad conditioning
//
// Purpose: derives clk1/clk2 from sysclk, sequences subcycles A1..X3 with sync,
// generates POC, gate and TEST_n, and splits the data bus into in/out/oe pad
// signals; CM-ROM/CM-RAM lines are registered toward the pads.
// Optional feature macro: STOP_EN (adds stop_req input and stopped output).
//
// Ports:
//   sysclk, poc_pad         - system clock, synchronous active-high reset
//   clk1, clk2, phase, sync - two-phase clocks, one-hot subcycle, X3 marker
//   gate, poc               - DRAM input gate, cleaned power-on clear
//   core_dout, core_drive   - core data out and I/O-write drive request
//   core_din, din_valid     - captured pad data and its one-sysclk strobe
//   data_pad_i/o/oe         - FPGA pad input, output value, output enable
//   test_pad, test_n        - raw TEST pin, synchronised inverted TEST
//   cmrom/cmrom_pad, cmram/cmram_pad - memory selects toward pads
//   stop_req, stopped       - only with STOP_EN
module timing_io_gen #(
  parameter int DATA_W      = 4,
  parameter int NUM_CMRAM   = 4,
  parameter int PHASE_TICKS = 2
) (
  input  logic                 sysclk,
  input  logic                 poc_pad,
  output logic                 clk1,
  output logic                 clk2,
  output logic [7:0]           phase,
  output logic                 sync,
  output logic                 gate,
  output logic                 poc,
  input  logic [DATA_W-1:0]    core_dout,
  input  logic                 core_drive,
  output logic [DATA_W-1:0]    core_din,
  output logic                 din_valid,
  input  logic [DATA_W-1:0]    data_pad_i,
  output logic [DATA_W-1:0]    data_pad_o,
  output logic                 data_pad_oe,
  input  logic                 test_pad,
  output logic                 test_n,
  input  logic                 cmrom,
  output logic                 cmrom_pad,
  input  logic [NUM_CMRAM-1:0] cmram,
  output logic [NUM_CMRAM-1:0] cmram_pad
`ifdef STOP_EN
  ,
  input  logic                 stop_req,
  output logic                 stopped
`endif
);

  typedef enum logic [2:0] {
    SUB_A1, SUB_A2, SUB_A3, SUB_M1, SUB_M2, SUB_X1, SUB_X2, SUB_X3
  } sub_t;

  localparam logic [7:0] TICK_LAST = 8'(PHASE_TICKS - 1);

  logic [7:0] tick_q, tick_d;
  logic [1:0] quarter_q, quarter_d;
  sub_t       sub_q, sub_d;
  logic       tick_last, cyc_last, run;

  assign tick_last = (tick_q == TICK_LAST);
  assign cyc_last  = tick_last && (quarter_q == 2'd3) && (sub_q == SUB_X3);

`ifdef STOP_EN
  logic stop_q;

  // Frozen only while the stop is armed and still requested; dropping
  // stop_req lets the counters leave A1/quarter 0 on the same edge.
  assign run = !(stop_q && stop_req);

  always_ff @(posedge sysclk) begin
    if (poc_pad) begin
      stop_q  <= 1'b0;
      stopped <= 1'b0;
    end else begin
      if (stop_q)        stop_q <= stop_req;
      else if (cyc_last) stop_q <= stop_req;
      stopped <= !run;
    end
  end
`else
  assign run = 1'b1;
`endif

  // Sequencer state register
  always_ff @(posedge sysclk) begin
    if (poc_pad) begin
      tick_q    <= '0;
      quarter_q <= '0;
      sub_q     <= SUB_A1;
    end else begin
      tick_q    <= tick_d;
      quarter_q <= quarter_d;
      sub_q     <= sub_d;
    end
  end

  // Sequencer next state: tick -> quarter -> subcycle, X3 wraps to A1
  always_comb begin
    tick_d    = tick_q + 8'd1;
    quarter_d = quarter_q;
    sub_d     = sub_q;
    if (tick_last) begin
      tick_d    = '0;
      quarter_d = quarter_q + 2'd1;
      if (quarter_q == 2'd3) sub_d = sub_t'(sub_q + 3'd1);
    end
    if (!run) begin
      tick_d    = '0;
      quarter_d = '0;
      sub_d     = SUB_A1;
    end
  end

  // Bus direction decode. The X2 drive request is taken on the very first
  // tick of X2; the latched copy covers the rest of X2 and X3.
  logic seen_wrap, poc_now, drive_lat, x2_entry, drive_x, drive_sub, capture_sub;

  assign poc_now     = !seen_wrap;
  assign x2_entry    = (sub_q == SUB_X2) && (quarter_q == 2'd0) && (tick_q == 8'd0);
  assign drive_x     = x2_entry ? core_drive : drive_lat;
  assign drive_sub   = (sub_q <= SUB_A3) ||
                       (((sub_q == SUB_X2) || (sub_q == SUB_X3)) && drive_x);
  assign capture_sub = (sub_q == SUB_M1) || (sub_q == SUB_M2) || (sub_q == SUB_X1) ||
                       ((sub_q == SUB_X2) && !drive_x);

  logic test_s1;

  // Registered outputs decode the current sequencer position, so the first
  // sysclk after reset release presents A1/quarter 0.
  always_ff @(posedge sysclk) begin
    if (poc_pad) begin
      clk1        <= 1'b0;
      clk2        <= 1'b0;
      phase       <= '0;
      sync        <= 1'b0;
      gate        <= 1'b0;
      poc         <= 1'b1;
      seen_wrap   <= 1'b0;
      drive_lat   <= 1'b0;
      din_valid   <= 1'b0;
      data_pad_oe <= 1'b0;
      data_pad_o  <= '0;
      core_din    <= '0;
      cmrom_pad   <= 1'b0;
      cmram_pad   <= '0;
      test_s1     <= 1'b1;
      test_n      <= 1'b1;
    end else begin
      test_s1   <= ~test_pad;
      test_n    <= test_s1;
      seen_wrap <= seen_wrap | cyc_last;
      poc       <= poc_now;
      cmrom_pad <= cmrom & ~poc_now;
      cmram_pad <= poc_now ? '0 : cmram;
      din_valid <= 1'b0;

      if (run) begin
        clk1  <= (quarter_q == 2'd0);
        clk2  <= (quarter_q == 2'd2);
        phase <= 8'd1 << sub_q;
        sync  <= (sub_q == SUB_X3);
        gate  <= (sub_q == SUB_M1) || (sub_q == SUB_M2);
        if (x2_entry) drive_lat <= core_drive;
      end else begin
        clk1  <= 1'b0;
        clk2  <= 1'b0;
        phase <= '0;
        sync  <= 1'b0;
        gate  <= 1'b0;
      end

      if (poc_now) begin
        // Pads pulled to a driven zero until the core is out of power-on clear
        data_pad_oe <= 1'b1;
        data_pad_o  <= '0;
      end else if (run) begin
        data_pad_oe <= drive_sub;
        if (drive_sub && (quarter_q == 2'd1) && tick_last) data_pad_o <= core_dout;
        if (capture_sub && (quarter_q == 2'd2) && tick_last) begin
          core_din  <= data_pad_i;
          din_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timing_io_gen.sv
// tb/tb_timing_io_gen.sv - directed table-driven bench for timing_io_gen
module tb_timing_io_gen;

  logic       sysclk = 1'b0;
  logic       poc_pad, core_drive, test_pad, cmrom;
  logic [3:0] core_dout, data_pad_i, cmram;

  logic       clk1, clk2, sync, gate, poc, din_valid, oe, test_n, cmrom_pad;
  logic [7:0] phase;
  logic [3:0] core_din, dpo, cmram_pad;

  logic       e_clk1, e_clk2, e_sync, e_gate, e_poc, e_dv, e_oe, e_test_n, e_cmrom_pad;
  logic [7:0] e_phase;
  logic [3:0] e_core_din, e_dpo, e_cmram_pad;

`ifdef STOP_EN
  logic stop_req, stopped, e_stopped;
`endif

  always #5 sysclk = ~sysclk;

  timing_io_gen #(.DATA_W(4), .NUM_CMRAM(4), .PHASE_TICKS(2)) dut (
    .sysclk(sysclk), .poc_pad(poc_pad), .clk1(clk1), .clk2(clk2), .phase(phase),
    .sync(sync), .gate(gate), .poc(poc), .core_dout(core_dout), .core_drive(core_drive),
    .core_din(core_din), .din_valid(din_valid), .data_pad_i(data_pad_i),
    .data_pad_o(dpo), .data_pad_oe(oe), .test_pad(test_pad), .test_n(test_n),
    .cmrom(cmrom), .cmrom_pad(cmrom_pad), .cmram(cmram), .cmram_pad(cmram_pad)
`ifdef STOP_EN
    , .stop_req(stop_req), .stopped(stopped)
`endif
  );

  timing_io_gen #(.DATA_W(4), .NUM_CMRAM(4), .PHASE_TICKS(1)) dut1 (
    .sysclk(sysclk), .poc_pad(poc_pad), .clk1(e_clk1), .clk2(e_clk2), .phase(e_phase),
    .sync(e_sync), .gate(e_gate), .poc(e_poc), .core_dout(core_dout), .core_drive(core_drive),
    .core_din(e_core_din), .din_valid(e_dv), .data_pad_i(data_pad_i),
    .data_pad_o(e_dpo), .data_pad_oe(e_oe), .test_pad(test_pad), .test_n(e_test_n),
    .cmrom(cmrom), .cmrom_pad(e_cmrom_pad), .cmram(cmram), .cmram_pad(e_cmram_pad)
`ifdef STOP_EN
    , .stop_req(stop_req), .stopped(e_stopped)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pos;

  typedef struct {
    int         pos;
    logic       c1, c2;
    logic [7:0] ph;
    logic       sy, gt, pc, oe;
    logic [3:0] dpo;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s pos=%0d actual=%h expected=%h", name, pos, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge sysclk);
    @(negedge sysclk);
    pos++;
  endtask

  task automatic adv_to(input int p);
    while (pos < p) adv();
  endtask

  // Holds reset for two edges, checks every output at its reset value, then
  // releases; the next adv() lands on sequence position 0.
  task automatic do_reset(input string name);
    @(negedge sysclk);
    poc_pad = 1'b1;
    adv();
    adv();
    chk(name, {clk1, clk2, phase, sync, gate, poc, din_valid, oe, cmrom_pad,
               cmram_pad, core_din, dpo, test_n},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               4'h0, 4'h0, 4'h0, 1'b1});
    poc_pad = 1'b0;
    pos = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog pos=%0d actual=running expected=finished", pos);
    $fatal(1, "watchdog");
  end

  initial begin
    int poc_bad, pulses, pulse_pos, oe_bad, dpo_bad, m_bad;
    poc_pad = 1'b1; core_drive = 1'b0; test_pad = 1'b0; cmrom = 1'b1;
    core_dout = 4'h3; data_pad_i = 4'h0; cmram = 4'hF;
`ifdef STOP_EN
    stop_req = 1'b0;
`endif
    pos = 0;

    vt[0]  = '{0,   1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[1]  = '{1,   1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[2]  = '{2,   1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[3]  = '{4,   1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[4]  = '{7,   1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[5]  = '{8,   1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[6]  = '{24,  1'b1, 1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0};
    vt[7]  = '{40,  1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[8]  = '{56,  1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[9]  = '{63,  1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0};
    vt[10] = '{64,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
    vt[11] = '{67,  1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3};
    vt[12] = '{70,  1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3};
    vt[13] = '{88,  1'b1, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3};
    vt[14] = '{116, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3};
    vt[15] = '{122, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3};

    do_reset("reset_outs");

    // Sequencing table; the first instruction cycle is also swept for the
    // power-on-clear pad state (oe=1, data 0, cmrom forced low).
    poc_bad = 0;
    for (int i = 0; i < 16; i++) begin
      while (pos < vt[i].pos) begin
        adv();
        if (pos < 64 && !(poc === 1'b1 && oe === 1'b1 && dpo === 4'h0 &&
                          cmrom_pad === 1'b0 && cmram_pad === 4'h0 && din_valid === 1'b0))
          poc_bad++;
      end
      chk($sformatf("vec%0d", vt[i].pos), {clk1, clk2, phase, sync, gate, poc, oe, dpo},
          {vt[i].c1, vt[i].c2, vt[i].ph, vt[i].sy, vt[i].gt, vt[i].pc, vt[i].oe, vt[i].dpo});
    end
    chk("poc_hold_cycles", poc_bad, 0);

    // CM lines pass through with one sysclk of delay once poc is clear
    adv();
    chk("cm_pass", {cmrom_pad, cmram_pad}, {1'b1, 4'hF});
    cmrom = 1'b0; cmram = 4'h9;
    adv();
    chk("cm_delay", {cmrom_pad, cmram_pad}, {1'b0, 4'h9});

    // TEST synchroniser: two sysclk latency, inverted
    test_pad = 1'b1;
    adv();
    chk("test_n_lat1", test_n, 1'b1);
    adv();
    chk("test_n_lat2", test_n, 1'b0);

    // Capture in M1 of the instruction cycle starting at 128
    pulses = 0; pulse_pos = -1;
    while (pos < 159) begin
      adv();
      if (din_valid === 1'b1) begin pulses++; pulse_pos = pos; end
      if (pos == 150) data_pad_i = 4'hA;
    end
    chk("cap_pulses", pulses, 1);
    chk("cap_pulse_pos", pulse_pos, 157);
    chk("cap_data", core_din, 4'hA);

    // I/O write: drive requested at X2 entry (240), then dropped mid-X2
    adv_to(239);
    core_dout = 4'h5; core_drive = 1'b1;
    adv();
    chk("dpo_hold_x2_start", dpo, 4'h3);
    oe_bad = 0; dpo_bad = 0; pulses = 0;
    while (pos < 255) begin
      if (oe !== 1'b1) oe_bad++;
      if (pos >= 244 && dpo !== 4'h5) dpo_bad++;
      if (din_valid === 1'b1) pulses++;
      if (pos == 242) core_drive = 1'b0;
      adv();
    end
    if (oe !== 1'b1) oe_bad++;
    if (dpo !== 4'h5) dpo_bad++;
    chk("wr_oe_x2x3", oe_bad, 0);
    chk("wr_dout_x2x3", dpo_bad, 0);
    chk("wr_no_capture", pulses, 0);
    adv();
    chk("a1_oe_after_write", {oe, phase}, {1'b1, 8'h01});

    // Next cycle: no drive at X2 entry -> pad released, X2 captures instead
    adv_to(280);
    core_dout = 4'h7;
    adv_to(300);
    data_pad_i = 4'h6;
    oe_bad = 0; pulses = 0; pulse_pos = -1;
    while (pos < 319) begin
      adv();
      if (pos >= 304 && oe !== 1'b0) oe_bad++;
      if (din_valid === 1'b1) begin pulses++; pulse_pos = pos; end
    end
    chk("rd_oe_x2x3", oe_bad, 0);
    chk("rd_x2_capture_pos", pulse_pos, 309);
    chk("rd_x2_capture_data", core_din, 4'h6);
    chk("dpo_holds_undriven", dpo, 4'h5);

    // Reset in the middle of M2
    adv_to(355);
    chk("mid_m2_phase", phase, 8'h10);
    do_reset("reset_mid_m2");

    // Restart: PHASE_TICKS=2 instance at position 0, PHASE_TICKS=1 instance
    // against a quarter-per-sysclk model over two instruction cycles.
    m_bad = 0;
    for (int n = 0; n < 64; n++) begin
      logic [1:0] q;
      logic [2:0] s;
      logic       ep, edv, eoe;
      adv();
      if (n == 0) chk("restart_a1", {clk1, clk2, phase, poc}, {1'b1, 1'b0, 8'h01, 1'b1});
      q   = 2'(n % 4);
      s   = 3'((n / 4) % 8);
      ep  = (n < 32);
      edv = !ep && (s >= 3'd3) && (s <= 3'd6) && (q == 2'd2);
      eoe = ep || (s <= 3'd2);
      if ({e_clk1, e_clk2, e_phase, e_sync, e_poc, e_dv, e_oe} !==
          {q == 2'd0, q == 2'd2, 8'd1 << s, s == 3'd7, ep, edv, eoe}) begin
        m_bad++;
        if (m_bad == 1)
          $display("FAIL pt1_model pos=%0d actual=%b expected=%b", pos,
                   {e_clk1, e_clk2, e_phase, e_sync, e_poc, e_dv, e_oe},
                   {q == 2'd0, q == 2'd2, 8'd1 << s, s == 3'd7, ep, edv, eoe});
      end
    end
    n_checks++;
    if (m_bad != 0) n_fail++;

`ifdef STOP_EN
    adv_to(112);
    stop_req = 1'b1;
    adv_to(127);
    chk("stop_last_x3", {sync, stopped}, {1'b1, 1'b0});
    adv();
    chk("stop_idle", {stopped, clk1, clk2, phase, sync}, {1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    adv();
    adv();
    chk("stop_hold", {stopped, clk1, phase}, {1'b1, 1'b0, 8'h00});
    stop_req = 1'b0;
    adv();
    chk("stop_resume", {stopped, clk1, clk2, phase}, {1'b0, 1'b1, 1'b0, 8'h01});
    adv();
    adv();
    chk("stop_resume_q1", {clk1, phase}, {1'b0, 8'h01});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timing_io_gen.md
Name: timing_io_gen

Overview:
Parametrised next-generation timing and I/O pad block for the 4004 core. It generates the two-phase clk1/clk2 internally from sysclk, sequences the eight subcycles A1..X3 with sync, and produces the cleaned POC, gate and TEST signals. It conditions a DATA_W-bit bus as separate in/out/output-enable signals for FPGA pads, and registers NUM_CMRAM CM-RAM lines. It sits between the CPU core and the chip pads.

Parameters:
DATA_W, 4, data bus width in bits (1..16)
NUM_CMRAM, 4, number of CM-RAM select lines (1..8)
PHASE_TICKS, 2, sysclk cycles per clock quarter (1..255)

Ports:
sysclk  in  1  system clock; all logic on rising edge
poc_pad  in  1  reset, synchronous, active-high
clk1  out  1  phase-1 clock
clk2  out  1  phase-2 clock
phase  out  8  one-hot subcycle: bit0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3
sync  out  1  high throughout X3
gate  out  1  DRAM input gate
poc  out  1  cleaned power-on clear
core_dout  in  DATA_W  data from core to bus
core_drive  in  1  core requests bus drive in X2/X3 (I/O write)
core_din  out  DATA_W  captured pad data
din_valid  out  1  one-sysclk strobe when core_din updates
data_pad_i  in  DATA_W  pad input
data_pad_o  out  DATA_W  pad output value
data_pad_oe  out  1  pad output enable
test_pad  in  1  raw TEST pin
test_n  out  1  synchronised inverted TEST
cmrom  in  1  core CM-ROM
cmrom_pad  out  1  registered CM-ROM
cmram  in  NUM_CMRAM  core CM-RAM
cmram_pad  out  NUM_CMRAM  registered CM-RAM

Behaviour:
- Reset: tick=0, quarter=0, subcycle=A1; clk1, clk2, phase, sync, gate, din_valid, data_pad_oe, cmrom_pad, cmram_pad, core_din, data_pad_o = 0; poc=1; test_n=1. Reset mid-cycle aborts instantly; no partial phase continues.
- Tick counter 0..PHASE_TICKS-1; wrap advances quarter 0..3; quarter-3 wrap advances subcycle, X3 wraps to A1. Subcycle = 4*PHASE_TICKS sysclks; instruction cycle = 32*PHASE_TICKS.
- Outputs are registered, so the first cycle after reset release shows A1/quarter 0. clk1=1 in quarter 0, clk2=1 in quarter 2, both 0 in quarters 1 and 3; never simultaneously high.
- phase one-hot for the whole subcycle; sync = phase[7]; gate = phase[3]|phase[4].
- poc: held 1 from reset through the first full instruction cycle after release; clears on entry to the second A1. While poc=1: data_pad_oe=1, data_pad_o=0, cmrom_pad/cmram_pad forced 0, din_valid suppressed.
- Bus drive (poc=0): data_pad_oe=1 in A1, A2, A3 (address out) and in X2, X3 when core_drive was sampled 1 at X2 entry; otherwise 0. data_pad_o = core_dout registered on the last tick of quarter 1 of each driven subcycle; it holds in undriven subcycles.
- Capture: in M1, M2, X1 and X2 (when not driving), data_pad_i is registered into core_din on the last tick of quarter 2; din_valid pulses for exactly that one sysclk.
- test_n = ~test_pad through a 2-flop synchroniser (2 sysclk latency).
- cmrom_pad/cmram_pad = inputs delayed 1 sysclk.
- PHASE_TICKS=1: each quarter lasts 1 sysclk. The clk1/clk2 and sampling rules are unchanged.

Optional Feature:
STOP_EN: adds input stop_req and output stopped. With STOP_EN, stop_req sampled 1 at the X3 wrap freezes the block at A1/quarter 0 with clk1=clk2=0, phase=0, sync=0 and stopped=1. Release restarts at A1/quarter 0 on the next sysclk. Without STOP_EN, neither port exists and the sequence is free-running.

Test Plan:
- Reset, PHASE_TICKS=2: release -> clk1 high sysclk 0-1, clk2 high 4-5, phase=8'h01 for 8 sysclks, sync high sysclks 56-63, period 64.
- poc: release reset -> poc=1, data_pad_oe=1, data_pad_o=0 for 64 sysclks; poc=0 at sysclk 64 (second A1).
- Capture: data_pad_i=4'hA during M1 -> core_din=4'hA, din_valid single-cycle pulse at M1 tick 5; no pulse in A1..A3.
- I/O write: core_drive=1, core_dout=4'h5 at X2 entry -> data_pad_oe=1 throughout X2/X3 with data_pad_o=4'h5; core_drive=0 -> oe=0 in X2/X3.
- Reset asserted mid-M2 -> next cycle all outputs at reset values, poc=1; the sequence restarts at A1.
- STOP_EN: stop_req=1 in X2 -> after X3, stopped=1, clocks idle; drop stop_req -> A1 resumes, clk1 high next sysclk.
